xort_round_scheduler: RTL
=========================

XORT_ROUND_SCHEDULER -- requirements
Module: xort_round_scheduler

Interface
REQ-001 Parameter GAP_AB, default 10: minimum ticks from an a event to a following b event.
REQ-002 Parameter GAP_DC, default 7: minimum ticks from the last data event (a or b) to the clk event.
REQ-003 Parameter GAP_CD, default 8: minimum ticks from a clk event to the next data event.
REQ-004 Parameter DLY_Q, default 9: ticks from the clk event until the cell output is sampled as valid.
REQ-005 Parameter range: each of GAP_AB, GAP_DC, GAP_CD and DLY_Q SHALL be 1..255; values outside this range are unsupported.
REQ-006 clk  in  1  single clock; one tick = 1 ps of modelled cell time.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  round request valid.
REQ-009 in_ready  out  1  scheduler can accept a round.
REQ-010 in_a, in_b  in  1 each  data bits of the round, qualified by in_valid.
REQ-011 a_evt, b_evt, clk_evt  out  1 each  toggle lines to the XOR cell; each level change is one pulse.
REQ-012 out_valid  out  1  round result valid.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_x  out  1  expected XOR result of the round (in_a ^ in_b).
REQ-015 q_model  out  1  predicted cell output level; toggles when out_x = 1.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND_A, GAP1, SEND_B, GAP2, FIRE, WAIT_Q, RESULT and COOL.
REQ-018 in_ready SHALL be 1 only in IDLE; a round is accepted on the edge where in_valid && in_ready, and in_a/in_b are latched on that edge.
REQ-019 From IDLE on accept: go to SEND_A if a=1, else SEND_B if b=1, else FIRE.
REQ-020 SEND_A SHALL toggle a_evt for exactly one cycle, then go to GAP1 if b=1, else to GAP2.
REQ-021 GAP1 SHALL hold so that the b_evt toggle occurs exactly GAP_AB ticks after the a_evt toggle, then go to SEND_B.
REQ-022 SEND_B SHALL toggle b_evt once, then go to GAP2.
REQ-023 GAP2 SHALL hold so that the clk_evt toggle occurs exactly GAP_DC ticks after the last data toggle.
REQ-024 An empty round (a=b=0) SHALL go IDLE->FIRE directly with no GAP2 wait.
REQ-025 FIRE SHALL toggle clk_evt once, then go to WAIT_Q.
REQ-026 out_valid SHALL rise exactly DLY_Q ticks after the clk_evt toggle.
REQ-027 out_x SHALL be a^b of the round.
REQ-028 q_model SHALL toggle on the same edge that out_valid rises, only if out_x = 1.
REQ-029 RESULT SHALL hold out_valid and out_x stable until out_ready = 1; the handshake completes on that edge, and the FSM then goes to COOL.
REQ-030 COOL SHALL enforce GAP_CD: IDLE (in_ready=1) is re-entered so that the next data toggle occurs no earlier than GAP_CD ticks after the clk_evt toggle; ticks spent in WAIT_Q and RESULT count toward GAP_CD.
REQ-031 Each state with a wait SHALL use a single 8-bit down-counter, loaded on state entry and never wrapping.
REQ-032 At most one of a_evt/b_evt/clk_evt SHALL change on any clock edge.
REQ-033 in_valid deasserting before acceptance SHALL be legal; inputs not sampled at acceptance SHALL be ignored.

Reset
REQ-034 While rst_n = 0, asynchronously and regardless of state: FSM=IDLE; a_evt=b_evt=clk_evt=0; out_valid=0; out_x=0; q_model=0; counter=0; in_ready=0.
REQ-035 in_ready SHALL assert on the first edge after rst_n deasserts.
REQ-036 Reset mid-round SHALL abort the round with no further toggles and no result.

Verification
REQ-037 Round a=1,b=0, defaults -> a_evt toggles at t0, clk_evt at t0+7, out_valid at t0+16 with out_x=1, q_model 0->1.
REQ-038 Round a=1,b=1 -> a_evt at t0, b_evt at t0+10, clk_evt at t0+17, out_x=0, q_model unchanged.
REQ-039 Round a=0,b=0 -> only clk_evt toggles, out_x=0; the next round's first data toggle occurs ≥8 ticks after that clk_evt.
REQ-040 Back-to-back rounds with out_ready held 1 -> a monitor on the toggle lines sees no GAP_AB/GAP_DC/GAP_CD violation over 1000 random rounds, and q_model equals the XOR of all out_x values.
REQ-041 out_ready held 0 for 20 cycles -> out_valid/out_x stay stable, in_ready stays 0, and no toggles occur.
REQ-042 rst_n pulsed low during GAP1 -> all outputs go to 0 immediately, no b_evt is issued, and in_ready=1 one edge after release.

Source files
------------

// File: rtl/xort_round_scheduler.sv
// xort_round_scheduler
//   Sequences one XOR-cell round: toggles a_evt/b_evt for the data bits,
//   then clk_evt, and presents the predicted result DLY_Q ticks later.
//   One tick is one clk cycle. All event lines are toggles: each level
//   change is one pulse. Event timing is enforced with one shared 8-bit
//   saturating down-counter, loaded on entry to each waiting state.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   round request valid
//   in_ready   scheduler can accept a round (IDLE only)
//   in_a/in_b  data bits, latched on accept
//   a_evt      toggle line, data a
//   b_evt      toggle line, data b
//   clk_evt    toggle line, cell clock
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   out_x      expected XOR of the round
//   q_model    predicted cell output level
//   busy       high outside IDLE
//
// State    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a round (in_ready=1 once out of reset)
// SEND_A   | a_evt toggled on entry, one cycle
// GAP1     | hold so b_evt lands GAP_AB ticks after a_evt
// SEND_B   | b_evt toggled on entry, one cycle
// GAP2     | hold so clk_evt lands GAP_DC ticks after last data toggle
// FIRE     | clk_evt toggled on entry, one cycle
// WAIT_Q   | hold so out_valid rises DLY_Q ticks after clk_evt
// RESULT   | out_valid held until out_ready
// COOL     | hold so the next accept is >= GAP_CD ticks after clk_evt
module xort_round_scheduler #(
  parameter int unsigned GAP_AB = 10,
  parameter int unsigned GAP_DC = 7,
  parameter int unsigned GAP_CD = 8,
  parameter int unsigned DLY_Q  = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_a,
  input  logic in_b,
  output logic a_evt,
  output logic b_evt,
  output logic clk_evt,
  output logic out_valid,
  input  logic out_ready,
  output logic out_x,
  output logic q_model,
  output logic busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_A, S_GAP1, S_SEND_B, S_GAP2,
    S_FIRE, S_WAIT_Q, S_RESULT, S_COOL
  } state_e;

  // Toggles happen on the edge that enters SEND_A/SEND_B/FIRE, so a gap
  // of G ticks needs G-1 cycles in the gap state; the counter runs
  // G-2 .. 0. A gap of 1 skips the gap state entirely.
  localparam logic [7:0] LD_AB = 8'(GAP_AB - 2);
  localparam logic [7:0] LD_DC = 8'(GAP_DC - 2);
  localparam logic [7:0] LD_Q  = 8'(DLY_Q - 2);
  // In RESULT/COOL the counter holds how many more edges must pass before
  // IDLE may be entered (IDLE entry at clk_evt + GAP_CD - 1 lets the next
  // accept, and thus the next data toggle, land at clk_evt + GAP_CD).
  localparam int unsigned CD_REM = (GAP_CD > DLY_Q + 1) ? (GAP_CD - 1 - DLY_Q) : 0;
  localparam logic [7:0] LD_RES = 8'(CD_REM);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_dec;
  logic       rdy_en_q;
  logic       b_q, b_d;
  logic       a_evt_q, a_evt_d;
  logic       b_evt_q, b_evt_d;
  logic       clk_evt_q, clk_evt_d;
  logic       out_valid_q, out_valid_d;
  logic       out_x_q, out_x_d;
  logic       q_model_q, q_model_d;
  logic       accept, enter;

  assign accept  = in_valid && rdy_en_q && (state_q == S_IDLE);
  assign cnt_dec = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) begin
                  if (in_a)      state_d = S_SEND_A;
                  else if (in_b) state_d = S_SEND_B;
                  else           state_d = S_FIRE;
                end
      S_SEND_A: if (b_q) state_d = (GAP_AB > 1) ? S_GAP1 : S_SEND_B;
                else     state_d = (GAP_DC > 1) ? S_GAP2 : S_FIRE;
      S_GAP1:   if (cnt_q == 8'd0) state_d = S_SEND_B;
      S_SEND_B: state_d = (GAP_DC > 1) ? S_GAP2 : S_FIRE;
      S_GAP2:   if (cnt_q == 8'd0) state_d = S_FIRE;
      S_FIRE:   state_d = (DLY_Q > 1) ? S_WAIT_Q : S_RESULT;
      S_WAIT_Q: if (cnt_q == 8'd0) state_d = S_RESULT;
      S_RESULT: if (out_ready) state_d = S_COOL;
      S_COOL:   if (cnt_q <= 8'd1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    in_ready = rdy_en_q && (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  // Datapath next values; all event toggles are tied to state entry
  always_comb begin
    enter       = (state_d != state_q);
    a_evt_d     = a_evt_q   ^ (enter && (state_d == S_SEND_A));
    b_evt_d     = b_evt_q   ^ (enter && (state_d == S_SEND_B));
    clk_evt_d   = clk_evt_q ^ (enter && (state_d == S_FIRE));
    out_valid_d = (state_d == S_RESULT);
    q_model_d   = q_model_q ^ (enter && (state_d == S_RESULT) && out_x_q);
    out_x_d     = accept ? (in_a ^ in_b) : out_x_q;
    b_d         = accept ? in_b : b_q;
    cnt_d       = cnt_dec;
    if (enter) begin
      case (state_d)
        S_GAP1:   cnt_d = LD_AB;
        S_GAP2:   cnt_d = LD_DC;
        S_WAIT_Q: cnt_d = LD_Q;
        S_RESULT: cnt_d = LD_RES;
        S_IDLE:   cnt_d = 8'd0;
        default:  cnt_d = cnt_dec;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 8'd0;
      rdy_en_q    <= 1'b0;
      b_q         <= 1'b0;
      a_evt_q     <= 1'b0;
      b_evt_q     <= 1'b0;
      clk_evt_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= 1'b0;
      q_model_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rdy_en_q    <= 1'b1;
      b_q         <= b_d;
      a_evt_q     <= a_evt_d;
      b_evt_q     <= b_evt_d;
      clk_evt_q   <= clk_evt_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      q_model_q   <= q_model_d;
    end
  end

  assign a_evt     = a_evt_q;
  assign b_evt     = b_evt_q;
  assign clk_evt   = clk_evt_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign q_model   = q_model_q;

endmodule
